fifo_mem_par: RTL and testbench
===============================

// Module: fifo_mem_par
// PURPOSE
//  Next-generation dual-clock FIFO storage array for the async FIFO. Stores DATA_WIDTH words
//  plus one even-parity bit per entry. Read port is either combinational or registered
//  (READ_MODE), with parity checking on every read. Counts writes dropped while full.
//  Sits between the write-pointer/full logic (W_CLK domain) and read-pointer/empty logic (R_CLK).
// PARAMETERS
//  DATA_WIDTH  8  payload width in bits
//  ADDR_SIZE   3  address width; depth = 2**ADDR_SIZE entries
//  READ_MODE   0  0 = combinational read, 1 = registered read on R_INC
//  CNT_WIDTH   8  width of the saturating drop counter
// PORTS
//  W_CLK       in   1           write-domain clock
//  W_RST       in   1           write-domain reset, asynchronous, active-low
//  R_CLK       in   1           read-domain clock (used only when READ_MODE=1)
//  R_RST       in   1           read-domain reset, asynchronous, active-low
//  W_INC       in   1           write request
//  FIFO_Full   in   1           full flag from write-pointer logic
//  W_Addr      in   ADDR_SIZE   write address
//  W_Data      in   DATA_WIDTH  write data
//  W_Par_Inj   in   1           test: invert the stored parity bit of this write
//  W_Drop_Clr  in   1           synchronous clear of W_Drop_Cnt
//  W_Drop_Cnt  out  CNT_WIDTH   writes rejected because FIFO_Full was high
//  R_INC       in   1           read request (READ_MODE=1)
//  FIFO_Empty  in   1           empty flag from read-pointer logic
//  R_Addr      in   ADDR_SIZE   read address
//  R_Data      out  DATA_WIDTH  read data
//  R_Valid     out  1           R_Data is valid
//  R_Par_Err   out  1           parity mismatch on the word in R_Data
// BEHAVIOUR
//  Storage: 2**ADDR_SIZE entries of {par, data}; stored par = ^W_Data ^ W_Par_Inj.
//  W_RST low: all entries (data and par) = 0 (parity-consistent); W_Drop_Cnt = 0.
//  Write: at posedge W_CLK, if W_INC && !FIFO_Full, mem[W_Addr] <= {par, W_Data}.
//   If FIFO_Full is high, memory is unchanged.
//  Drop counter: at posedge W_CLK, W_INC && FIFO_Full increments the counter, saturating at
//   2**CNT_WIDTH-1 (no wrap). W_Drop_Clr alone -> 0. Clear and drop in the same cycle -> 1.
//  Parity check: err = ^{par, data} of the addressed entry (1 = odd = error).
//  READ_MODE=0: R_Data = mem[R_Addr].data, R_Par_Err = err, R_Valid = !FIFO_Empty.
//   All three are combinational with zero latency. R_CLK, R_RST and R_INC are ignored.
//  READ_MODE=1: R_Data, R_Valid and R_Par_Err are registered on R_CLK.
//   R_RST low: R_Data = 0, R_Valid = 0, R_Par_Err = 0.
//   Posedge R_CLK with R_INC && !FIFO_Empty: R_Data <= mem[R_Addr].data,
//    R_Par_Err <= err, R_Valid <= 1. Latency is 1 R_CLK cycle.
//   Otherwise: R_Valid <= 0, R_Par_Err <= 0, R_Data holds its last value.
//   R_INC while FIFO_Empty is ignored; no read occurs.
//  Address collision: pointer logic guarantees R_Addr == W_Addr only when full or empty.
//   Full blocks the write and empty blocks the read, so no read-during-write hazard exists.
//  Wrap-around: addresses are modulo depth. The pointer logic does the wrapping;
//   this block has no address state.
//  W_RST mid-operation clears memory. A read issued afterwards returns 0 with R_Par_Err = 0.
//  R_RST mid-operation clears only the read registers; memory contents are unchanged.
// TESTING
//  1 Reset, then READ_MODE=0, write 0xA5 to addr 2, R_Addr=2, FIFO_Empty=0
//     -> R_Data=0xA5, R_Valid=1, R_Par_Err=0.
//  2 Fill all 8 addresses with 0x10..0x17; raise FIFO_Full, write 0xFF to addr 0 three times
//     -> mem[0] still 0x10, W_Drop_Cnt=3.
//  3 CNT_WIDTH=2: drop 5 writes -> W_Drop_Cnt saturates at 3.
//     Assert Clr with a drop in the same cycle -> 1.
//  4 Write 0x3C with W_Par_Inj=1 to addr 5, then read it -> R_Par_Err=1, R_Data=0x3C.
//     Rewrite addr 5 with W_Par_Inj=0 and read -> R_Par_Err=0.
//  5 READ_MODE=1, async clocks (W 10ns, R 14ns): stream 64 random words through a model
//     pointer FIFO -> in-order data, one R_Valid pulse per accepted R_INC, R_INC on empty ignored.
//  6 Assert R_RST mid-stream -> R_Valid/R_Data/R_Par_Err=0 immediately.
//     Subsequent reads return the pre-reset stored data.

Source files
------------

// File: rtl/fifo_mem_par.sv
// rtl/fifo_mem_par.sv - dual-clock FIFO storage array with per-entry even parity
//
// Storage array sitting between the write-pointer/full logic (W_CLK domain)
// and the read-pointer/empty logic (R_CLK domain).
//
// Ports:
//   W_CLK, W_RST       write clock, asynchronous active-low write reset
//   R_CLK, R_RST       read clock/reset, only used when READ_MODE = 1
//   W_INC, FIFO_Full   write request, full flag (full blocks the write)
//   W_Addr, W_Data     write address and payload
//   W_Par_Inj          invert the stored parity bit of this write
//   W_Drop_Clr         synchronous clear of W_Drop_Cnt
//   W_Drop_Cnt         saturating count of writes rejected while full
//   R_INC, FIFO_Empty  read request (READ_MODE = 1), empty flag
//   R_Addr             read address
//   R_Data, R_Valid    read payload and its valid flag
//   R_Par_Err          parity mismatch on the word in R_Data
`timescale 1ns/1ps
module fifo_mem_par #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3,
  parameter int READ_MODE  = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  W_INC,
  input  logic                  FIFO_Full,
  input  logic [ADDR_SIZE-1:0]  W_Addr,
  input  logic [DATA_WIDTH-1:0] W_Data,
  input  logic                  W_Par_Inj,
  input  logic                  W_Drop_Clr,
  output logic [CNT_WIDTH-1:0]  W_Drop_Cnt,
  input  logic                  R_INC,
  input  logic                  FIFO_Empty,
  input  logic [ADDR_SIZE-1:0]  R_Addr,
  output logic [DATA_WIDTH-1:0] R_Data,
  output logic                  R_Valid,
  output logic                  R_Par_Err
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Each entry is {parity, data}; reset value 0 is parity-consistent.
  logic [DATA_WIDTH:0]  mem_q [DEPTH];
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                 wr_en, drop;
  logic [DATA_WIDTH:0]  rd_word;
  logic                 rd_err;

  assign wr_en = W_INC && !FIFO_Full;
  assign drop  = W_INC && FIFO_Full;

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[W_Addr] <= {(^W_Data) ^ W_Par_Inj, W_Data};
    end
  end

  // Clear wins over the old count, but a drop in the same cycle still counts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (W_Drop_Clr) begin
      drop_cnt_d    = '0;
      drop_cnt_d[0] = drop;
    end else if (drop && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign W_Drop_Cnt = drop_cnt_q;

  // Odd parity over {par, data} flags a corrupted entry.
  assign rd_word = mem_q[R_Addr];
  assign rd_err  = ^rd_word;

  generate
    if (READ_MODE == 0) begin : g_comb_rd
      logic unused_rd;
      assign unused_rd = ^{R_CLK, R_RST, R_INC};
      assign R_Data    = rd_word[DATA_WIDTH-1:0];
      assign R_Par_Err = rd_err;
      assign R_Valid   = !FIFO_Empty;
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] r_data_q;
      logic                  r_valid_q, r_err_q;

      always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
          r_data_q  <= '0;
          r_valid_q <= 1'b0;
          r_err_q   <= 1'b0;
        end else if (R_INC && !FIFO_Empty) begin
          r_data_q  <= rd_word[DATA_WIDTH-1:0];
          r_valid_q <= 1'b1;
          r_err_q   <= rd_err;
        end else begin
          // Data holds so the last word stays observable between reads.
          r_valid_q <= 1'b0;
          r_err_q   <= 1'b0;
        end
      end

      assign R_Data    = r_data_q;
      assign R_Valid   = r_valid_q;
      assign R_Par_Err = r_err_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_mem_par.sv
// tb/tb_fifo_mem_par.sv - testbench for fifo_mem_par (combinational and registered read)
`timescale 1ns/1ps
module tb_fifo_mem_par;

  logic       W_CLK = 1'b0, R_CLK = 1'b0;
  logic       W_RST = 1'b0, R_RST = 1'b0;
  logic       W_INC = 1'b0, FIFO_Full = 1'b0, W_Par_Inj = 1'b0, W_Drop_Clr = 1'b0;
  logic [2:0] W_Addr = '0, R_Addr = '0;
  logic [7:0] W_Data = '0;
  logic       R_INC = 1'b0, FIFO_Empty = 1'b1;

  logic [7:0] a_cnt, a_data, b_data;
  logic [1:0] b_cnt;
  logic       a_valid, a_err, b_valid, b_err;

  always #5 W_CLK = ~W_CLK;
  always #7 R_CLK = ~R_CLK;

  fifo_mem_par #(.DATA_WIDTH(8), .ADDR_SIZE(3), .READ_MODE(0), .CNT_WIDTH(8)) dut_a (
    .W_CLK(W_CLK), .W_RST(W_RST), .R_CLK(R_CLK), .R_RST(R_RST),
    .W_INC(W_INC), .FIFO_Full(FIFO_Full), .W_Addr(W_Addr), .W_Data(W_Data),
    .W_Par_Inj(W_Par_Inj), .W_Drop_Clr(W_Drop_Clr), .W_Drop_Cnt(a_cnt),
    .R_INC(R_INC), .FIFO_Empty(FIFO_Empty), .R_Addr(R_Addr),
    .R_Data(a_data), .R_Valid(a_valid), .R_Par_Err(a_err));

  fifo_mem_par #(.DATA_WIDTH(8), .ADDR_SIZE(3), .READ_MODE(1), .CNT_WIDTH(2)) dut_b (
    .W_CLK(W_CLK), .W_RST(W_RST), .R_CLK(R_CLK), .R_RST(R_RST),
    .W_INC(W_INC), .FIFO_Full(FIFO_Full), .W_Addr(W_Addr), .W_Data(W_Data),
    .W_Par_Inj(W_Par_Inj), .W_Drop_Clr(W_Drop_Clr), .W_Drop_Cnt(b_cnt),
    .R_INC(R_INC), .FIFO_Empty(FIFO_Empty), .R_Addr(R_Addr),
    .R_Data(b_data), .R_Valid(b_valid), .R_Par_Err(b_err));

  int n_checks = 0, n_pass = 0;

  // Reference model: stored {par, data} per address and the two drop counts.
  logic [8:0] mem_m [8];
  int         cnt_a = 0, cnt_b = 0;

  // Stream model: pointer FIFO of {expected_err, data}.
  logic [8:0] exp_q [$];
  int         wptr = 0, rptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int next_cnt(input int cnt, input bit drop, input bit clr, input int max);
    if (clr) return drop ? 1 : 0;
    if (drop) return (cnt + 1 > max) ? max : cnt + 1;
    return cnt;
  endfunction

  task automatic wr(input bit inc, input logic [2:0] a, input logic [7:0] d,
                    input bit inj, input bit full, input bit clr);
    @(negedge W_CLK);
    W_INC = inc; W_Addr = a; W_Data = d; W_Par_Inj = inj; FIFO_Full = full; W_Drop_Clr = clr;
    @(posedge W_CLK);
    #1;
    W_INC = 1'b0; W_Par_Inj = 1'b0; FIFO_Full = 1'b0; W_Drop_Clr = 1'b0;
    if (inc && !full) mem_m[a] = {(^d) ^ inj, d};
    cnt_a = next_cnt(cnt_a, inc && full, clr, 255);
    cnt_b = next_cnt(cnt_b, inc && full, clr, 3);
  endtask

  task automatic rd0(input string tag, input logic [2:0] a);
    R_Addr = a; FIFO_Empty = 1'b0;
    #1;
    check({tag, "_data"},  a_data,  mem_m[a][7:0]);
    check({tag, "_err"},   a_err,   ^mem_m[a]);
    check({tag, "_valid"}, a_valid, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem_m[i] = '0;

    // Reset state
    #12;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_data",  a_data,  8'h00);
    check("rst_a_err",   a_err,   1'b0);
    check("rst_a_cnt",   a_cnt,   8'h00);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_data",  b_data,  8'h00);
    check("rst_b_cnt",   b_cnt,   2'd0);
    @(negedge W_CLK);
    W_RST = 1'b1; R_RST = 1'b1;

    // Single write and combinational read
    wr(1, 3'd2, 8'hA5, 0, 0, 0);
    rd0("t1", 3'd2);
    check("t1_lit", a_data, 8'hA5);

    // Fill, then writes blocked by full
    for (int i = 0; i < 8; i++) wr(1, 3'(i), 8'h10 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 8; i++) rd0("fill", 3'(i));
    repeat (3) wr(1, 3'd0, 8'hFF, 0, 1, 0);
    rd0("t2_blocked", 3'd0);
    check("t2_lit",   a_data, 8'h10);
    check("t2_cnt_a", a_cnt,  cnt_a);
    check("t2_cnt_b", b_cnt,  cnt_b);

    // Saturation on the 2-bit counter, clear with and without a drop
    repeat (2) wr(1, 3'd0, 8'hFF, 0, 1, 0);
    check("t3_sat_b",  b_cnt, cnt_b);
    check("t3_cnt_a",  a_cnt, cnt_a);
    wr(1, 3'd0, 8'hFF, 0, 1, 1);
    check("t3_clrdrop_a", a_cnt, cnt_a);
    check("t3_clrdrop_b", b_cnt, cnt_b);
    wr(0, 3'd0, 8'h00, 0, 0, 1);
    check("t3_clr_a", a_cnt, cnt_a);
    check("t3_clr_b", b_cnt, cnt_b);

    // Parity injection
    wr(1, 3'd5, 8'h3C, 1, 0, 0);
    rd0("t4_inj", 3'd5);
    check("t4_inj_lit", a_err, 1'b1);
    wr(1, 3'd5, 8'h3C, 0, 0, 0);
    rd0("t4_clean", 3'd5);

    // Random writes, some blocked, some with injected parity
    for (int i = 0; i < 24; i++)
      wr(1, 3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3) == 0,
         $urandom_range(0, 3) == 0, 0);
    for (int i = 0; i < 8; i++) rd0("rand", 3'(i));
    check("rand_cnt_a", a_cnt, cnt_a);
    check("rand_cnt_b", b_cnt, cnt_b);

    // W_RST mid-operation clears the array and the counter
    @(negedge W_CLK);
    W_RST = 1'b0;
    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    cnt_a = 0; cnt_b = 0;
    #2;
    for (int i = 0; i < 8; i++) rd0("wrst", 3'(i));
    check("wrst_cnt_a", a_cnt, 8'h00);
    check("wrst_cnt_b", b_cnt, 2'd0);
    @(negedge W_CLK);
    W_RST = 1'b1;
    FIFO_Empty = 1'b1;
    #1;
    check("b_idle_valid", b_valid, 1'b0);

    // Registered read streaming across asynchronous clocks, with R_RST mid-stream
    fork
      begin : writer
        int sent = 0, wcyc = 0;
        bit inc, full, inj;
        logic [7:0] d;
        repeat (3) @(negedge W_CLK);
        while (sent < 64 && wcyc < 3000) begin
          @(negedge W_CLK);
          wcyc++;
          full = ((wptr - rptr) == 8);
          inc  = $urandom_range(0, 1) == 1;
          inj  = $urandom_range(0, 7) == 0;
          d    = 8'($urandom);
          FIFO_Full = full; W_INC = inc; W_Addr = 3'(wptr % 8); W_Data = d; W_Par_Inj = inj;
          @(posedge W_CLK);
          #1;
          if (inc && !full) begin
            exp_q.push_back({inj, d});
            wptr++;
            sent++;
          end
        end
        @(negedge W_CLK);
        W_INC = 1'b0; FIFO_Full = 1'b0; W_Par_Inj = 1'b0;
        check("stream_sent", sent, 64);
      end
      begin : reader
        int got = 0, rcyc = 0;
        bit inc, emp, did_rst = 0;
        logic [7:0] last = 8'h00;
        logic [8:0] e;
        while (got < 64 && rcyc < 3000) begin
          @(negedge R_CLK);
          rcyc++;
          if (got == 30 && !did_rst) begin
            R_INC = 1'b0;
            R_RST = 1'b0;
            #1;
            check("rrst_valid", b_valid, 1'b0);
            check("rrst_data",  b_data,  8'h00);
            check("rrst_err",   b_err,   1'b0);
            @(negedge R_CLK);
            R_RST = 1'b1;
            last = 8'h00;
            did_rst = 1;
          end
          emp = (wptr == rptr);
          inc = (rcyc < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
          FIFO_Empty = emp; R_Addr = 3'(rptr % 8); R_INC = inc;
          @(posedge R_CLK);
          #1;
          if (inc && !emp) begin
            e = exp_q.pop_front();
            check("strm_valid", b_valid, 1'b1);
            check("strm_data",  b_data,  e[7:0]);
            check("strm_err",   b_err,   e[8]);
            last = e[7:0];
            rptr++;
            got++;
          end else begin
            check("idle_valid", b_valid, 1'b0);
            check("idle_err",   b_err,   1'b0);
            check("idle_hold",  b_data,  last);
          end
        end
        R_INC = 1'b0;
        check("stream_got", got, 64);
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
